// File: rtl/sccb_pkg.sv
// -----------------------------------------------------------------------------
// sccb_pkg
// Shared definitions for the SCCB 3-phase write engine.
//   state_e         : engine FSM states
//   Q0..Q3          : quarter-phase indices inside one SCL bit period
//   TRANS_QUARTERS  : quarters in one complete START..STOP frame
//   *_LSB           : byte-field offsets inside the 24-bit request word
//   wr_byte()       : pick byte 0 (ID), 1 (sub-address) or 2 (data) of a word
// -----------------------------------------------------------------------------
package sccb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    BIT,
    ACK,
    STOP,
    DONE
  } state_e;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  // START (1 phase) + 3 bytes x 9 bit slots + STOP (1 phase), 4 quarters each
  localparam int unsigned TRANS_QUARTERS = 4 + 27 * 4 + 4;

  localparam int unsigned ID_LSB   = 16;
  localparam int unsigned ADDR_LSB = 8;
  localparam int unsigned DATA_LSB = 0;

  // Width of the automatic-retry counter; bounds the legal MAX_RETRY.
  localparam int unsigned RETRY_W = 4;

  function automatic logic [7:0] wr_byte(input logic [23:0] w, input logic [1:0] idx);
    case (idx)
      2'd0:    wr_byte = w[ID_LSB   +: 8];
      2'd1:    wr_byte = w[ADDR_LSB +: 8];
      default: wr_byte = w[DATA_LSB +: 8];
    endcase
  endfunction

endpackage

// File: rtl/sccb_phase_writer_if.sv
// -----------------------------------------------------------------------------
// sccb_phase_writer_if
// Request/response handshake between the register-init sequencer (master)
// and the SCCB write engine (slave).
//   start   : single-cycle request, honoured only while busy=0
//   wr_data : {ID, sub-address, data}
//   busy    : engine is running a transaction
//   done    : one-cycle end-of-transaction pulse
//   ack_err : at least one ACK slot sampled high in the last transaction
// -----------------------------------------------------------------------------
interface sccb_phase_writer_if;
  logic        start;
  logic [23:0] wr_data;
  logic        busy;
  logic        done;
  logic        ack_err;

  modport master (output start, output wr_data, input busy, input done, input ack_err);
  modport slave  (input start, input wr_data, output busy, output done, output ack_err);
endinterface

// File: rtl/sccb_quarter_tick.sv
// -----------------------------------------------------------------------------
// sccb_quarter_tick
// Divides the system clock into SCL quarter periods.
//   clk, rst : system clock, synchronous active-high reset
//   clr_i    : restart counter and quarter index from zero
//   en_i     : count while high (engine busy)
//   tick_o   : high in the last system clock of each quarter
//   qidx_o   : current quarter index 0..3 within the SCL bit
// -----------------------------------------------------------------------------
module sccb_quarter_tick #(
  parameter int unsigned CLK_DIV = 250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_i,
  input  logic       en_i,
  output logic       tick_o,
  output logic [1:0] qidx_o
);

  localparam int unsigned   CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    qidx_q, qidx_d;

  assign tick_o = en_i && (cnt_q == LAST);
  assign qidx_o = qidx_q;

  always_comb begin
    cnt_d  = cnt_q;
    qidx_d = qidx_q;
    if (clr_i) begin
      cnt_d  = '0;
      qidx_d = '0;
    end else if (en_i) begin
      if (tick_o) begin
        cnt_d  = '0;
        qidx_d = qidx_q + 2'd1;  // wraps naturally: every phase is 4 quarters
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      qidx_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      qidx_q <= qidx_d;
    end
  end

endmodule

// File: rtl/sccb_phase_writer.sv
// -----------------------------------------------------------------------------
// sccb_phase_writer
// Bit-level SCCB 3-phase write engine: START, ID byte, sub-address byte,
// data byte (each followed by a 9th ACK slot), STOP. SCL timing is derived
// locally from clk via sccb_quarter_tick.
//   clk, rst   : system clock, synchronous active-high reset
//   bus        : sccb_phase_writer_if.slave (start/wr_data/busy/done/ack_err)
//   sccb_sclk  : SCL, push-pull
//   sccb_data  : SDA, open-drain (drives 0 or Z only)
// Optional build macro SCCB_RETRY_EN: on a NACKed frame, re-send the same
// word up to MAX_RETRY more times before reporting done.
// -----------------------------------------------------------------------------
module sccb_phase_writer
  import sccb_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 250,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic               clk,
  input  logic               rst,
  sccb_phase_writer_if.slave bus,
  output logic               sccb_sclk,
  inout  wire                sccb_data
);

  if (CLK_DIV < 4) begin : g_bad_clk_div
    $error("sccb_phase_writer: CLK_DIV must be >= 4");
  end
  if (MAX_RETRY > (2 ** RETRY_W) - 1) begin : g_bad_max_retry
    $error("sccb_phase_writer: MAX_RETRY exceeds retry counter width");
  end

  state_e      state_q, state_d;
  logic [23:0] shreg_q, shreg_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic        ack_err_q, ack_err_d;
  logic        sclk_q, sclk_d;
  logic        sda_oe_q, sda_oe_d;   // 1 = pull SDA low
  logic        sda_meta_q, sda_sync_q;
`ifdef SCCB_RETRY_EN
  logic [RETRY_W-1:0] retry_q, retry_d;
`endif

  logic       tick;
  logic [1:0] qidx;
  logic       busy;
  logic       accept;
  logic       qend;

  assign busy   = (state_q == START) || (state_q == BIT) ||
                  (state_q == ACK)   || (state_q == STOP);
  assign accept = bus.start && !busy;
  assign qend   = tick && (qidx == Q3);

  sccb_quarter_tick #(.CLK_DIV(CLK_DIV)) u_qtick (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (accept),
    .en_i   (busy),
    .tick_o (tick),
    .qidx_o (qidx)
  );

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    byte_idx_d = byte_idx_q;
    bit_idx_d  = bit_idx_q;
    ack_err_d  = ack_err_q;
    sclk_d     = 1'b1;
    sda_oe_d   = 1'b0;
`ifdef SCCB_RETRY_EN
    retry_d    = retry_q;
`endif
    unique case (state_q)
      // DONE lasts exactly one cycle; both states accept a new request.
      IDLE, DONE: begin
        state_d = IDLE;
        if (accept) begin
          state_d    = START;
          shreg_d    = bus.wr_data;
          byte_idx_d = 2'd0;
          bit_idx_d  = 3'd7;
          ack_err_d  = 1'b0;
`ifdef SCCB_RETRY_EN
          retry_d    = '0;
`endif
        end
      end
      START: begin
        sclk_d   = (qidx == Q0) || (qidx == Q1);
        sda_oe_d = (qidx != Q0);
        if (qend) state_d = BIT;
      end
      BIT: begin
        sclk_d   = (qidx == Q1) || (qidx == Q2);
        sda_oe_d = !shreg_q[23];
        if (qend) begin
          // Rotate rather than shift: after 24 bits the word is back intact,
          // so a retry can resend it without a second copy.
          shreg_d = {shreg_q[22:0], shreg_q[23]};
          if (bit_idx_q == 3'd0) state_d = ACK;
          else                   bit_idx_d = bit_idx_q - 3'd1;
        end
      end
      ACK: begin
        sclk_d = (qidx == Q1) || (qidx == Q2);
        if (tick && (qidx == Q2) && sda_sync_q) ack_err_d = 1'b1;
        if (qend) begin
          if (byte_idx_q < 2'd2) begin
            byte_idx_d = byte_idx_q + 2'd1;
            bit_idx_d  = 3'd7;
            state_d    = BIT;
          end else begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        sclk_d   = (qidx != Q0);
        sda_oe_d = (qidx == Q0) || (qidx == Q1);
        if (qend) begin
`ifdef SCCB_RETRY_EN
          if (ack_err_q && (retry_q < RETRY_W'(MAX_RETRY))) begin
            retry_d    = retry_q + 1'b1;
            ack_err_d  = 1'b0;
            byte_idx_d = 2'd0;
            bit_idx_d  = 3'd7;
            state_d    = START;
          end else begin
            state_d = DONE;
          end
`else
          state_d = DONE;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      byte_idx_q <= '0;
      bit_idx_q  <= 3'd7;
      ack_err_q  <= 1'b0;
      sclk_q     <= 1'b1;
      sda_oe_q   <= 1'b0;
      sda_meta_q <= 1'b1;
      sda_sync_q <= 1'b1;
`ifdef SCCB_RETRY_EN
      retry_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      byte_idx_q <= byte_idx_d;
      bit_idx_q  <= bit_idx_d;
      ack_err_q  <= ack_err_d;
      sclk_q     <= sclk_d;      // pads registered: glitch-free, one clock behind decode
      sda_oe_q   <= sda_oe_d;
      sda_meta_q <= sccb_data;
      sda_sync_q <= sda_meta_q;
`ifdef SCCB_RETRY_EN
      retry_q    <= retry_d;
`endif
    end
  end

  assign sccb_sclk   = sclk_q;
  assign sccb_data   = sda_oe_q ? 1'b0 : 1'bz;
  assign bus.busy    = busy;
  assign bus.done    = (state_q == DONE);
  assign bus.ack_err = ack_err_q;

endmodule

// File: tb/tb_sccb_phase_writer.sv
// -----------------------------------------------------------------------------
// tb_sccb_phase_writer
// Directed bench for sccb_phase_writer with a behavioural SCCB slave that
// detects START/STOP, captures bytes on SCL rising edges and ACKs/NACKs per
// byte. Expected results are queued when a request is issued and compared
// when done pulses.
// -----------------------------------------------------------------------------
module tb_sccb_phase_writer;
  import sccb_pkg::*;

  localparam int unsigned CLK_DIV   = 4;
  localparam int unsigned MAX_RETRY = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sccb_phase_writer_if bus ();
  wire  scl;
  wire  sda;
  logic slv_drv = 1'b0;
  pullup (sda);
  assign sda = slv_drv ? 1'b0 : 1'bz;

  sccb_phase_writer #(.CLK_DIV(CLK_DIV), .MAX_RETRY(MAX_RETRY)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .sccb_sclk (scl),
    .sccb_data (sda)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- behavioural slave / line monitor ----------------
  logic [2:0] nack_mask;   // bit b set: slave does not ACK byte b
  logic       scl_p = 1'b1, sda_p = 1'b1;
  logic       in_frame = 1'b0, ack_clk = 1'b0;
  logic [7:0] sh = '0;
  int         bitcnt = 0, byte_i = 0, n_start = 0, n_stop = 0;
  logic [7:0] cap_q[$];
  logic       ackb_q[$];

  always @(negedge clk) begin
    scl_p <= scl;
    sda_p <= sda;
    if (rst) begin
      slv_drv <= 1'b0;
    end else if (scl_p && scl && sda_p && !sda) begin
      in_frame <= 1'b1; bitcnt <= 0; ack_clk <= 1'b0; byte_i <= 0;
      slv_drv  <= 1'b0; n_start <= n_start + 1;
    end else if (scl_p && scl && !sda_p && sda && in_frame) begin
      in_frame <= 1'b0; slv_drv <= 1'b0; n_stop <= n_stop + 1;
    end else if (in_frame && !scl_p && scl) begin
      if (bitcnt < 8) begin
        sh     <= {sh[6:0], sda};
        bitcnt <= bitcnt + 1;
        if (bitcnt == 7) cap_q.push_back({sh[6:0], sda});
      end else begin
        ack_clk <= 1'b1;
        ackb_q.push_back(sda);
      end
    end else if (in_frame && scl_p && !scl) begin
      if (bitcnt == 8 && !ack_clk) begin
        slv_drv <= !nack_mask[byte_i];
      end else if (ack_clk) begin
        slv_drv <= 1'b0; ack_clk <= 1'b0; bitcnt <= 0; byte_i <= byte_i + 1;
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [23:0] data;
    logic        aerr;
    int          frames;
    int          lat;
    logic [2:0]  nack;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0, errors = 0;
  int   acc_cyc = 0, rd_ptr = 0, ack_ptr = 0, stop_base = 0, start_base = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; request is sampled on the following posedge.
  task automatic do_start(input logic [23:0] d, input logic ae, input int frames);
    exp_t e;
    bus.start   = 1'b1;
    bus.wr_data = d;
    @(negedge clk);
    bus.start  = 1'b0;
    acc_cyc    = cyc;
    rd_ptr     = cap_q.size();
    ack_ptr    = ackb_q.size();
    stop_base  = n_stop;
    start_base = n_start;
    check("accept_busy", 32'(bus.busy), 32'd1);
    check("accept_ack_err_clr", 32'(bus.ack_err), 32'd0);
    e.data   = d;
    e.aerr   = ae;
    e.frames = frames;
    e.lat    = frames * int'(TRANS_QUARTERS) * int'(CLK_DIV);
    e.nack   = nack_mask;
    exp_q.push_back(e);
  endtask

  task automatic wait_done(input string tag);
    exp_t e;
    bit   seen;
    int   nb, na, budget;
    e      = exp_q[0];
    budget = e.lat + 64;
    seen   = 1'b0;
    for (int n = 0; n < budget && !seen; n++) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    e = exp_q.pop_front();
    if (seen) begin
      check({tag, "_latency"}, 32'(cyc - acc_cyc), 32'(e.lat));
      check({tag, "_ack_err"}, 32'(bus.ack_err), 32'(e.aerr));
      check({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
      check({tag, "_starts"}, 32'(n_start - start_base), 32'(e.frames));
      check({tag, "_stops"}, 32'(n_stop - stop_base), 32'(e.frames));
      nb = cap_q.size() - rd_ptr;
      na = ackb_q.size() - ack_ptr;
      check({tag, "_nbytes"}, 32'(nb), 32'(3 * e.frames));
      for (int i = 0; i < 3 * e.frames && i < nb; i++)
        check($sformatf("%s_byte%0d", tag, i), 32'(cap_q[rd_ptr + i]),
              32'(wr_byte(e.data, 2'(i % 3))));
      for (int i = 0; i < 3 * e.frames && i < na; i++)
        check($sformatf("%s_ackbit%0d", tag, i), 32'(ackb_q[ack_ptr + i]),
              32'(e.nack[i % 3]));
      @(negedge clk);
      check({tag, "_done_pulse_1clk"}, 32'(bus.done), 32'd0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; bus.start = 1'b0; bus.wr_data = '0; nack_mask = '0;
    repeat (4) @(negedge clk);
    check("rst_sclk", 32'(scl), 32'd1);
    check("rst_sda", 32'(sda), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_ack_err", 32'(bus.ack_err), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // all bytes ACKed
    do_start(24'h72_12_80, 1'b0, 1);
    wait_done("t1");

    // data byte NACKed
    nack_mask = 3'b100;
`ifdef SCCB_RETRY_EN
    do_start(24'h42_34_56, 1'b1, MAX_RETRY + 1);
`else
    do_start(24'h42_34_56, 1'b1, 1);
`endif
    wait_done("t2");
    nack_mask = 3'b000;

    // start re-pulsed mid-transaction with other data is ignored
    do_start(24'hA5_0F_3C, 1'b0, 1);
    repeat (99) @(negedge clk);
    bus.start = 1'b1; bus.wr_data = 24'h11_22_33;
    @(negedge clk);
    bus.start = 1'b0;
    check("t3_busy_kept", 32'(bus.busy), 32'd1);
    wait_done("t3");
    n = 0;
    repeat (20) begin
      if (bus.done) n++;
      @(negedge clk);
    end
    check("t3_extra_done", 32'(n), 32'd0);

    // reset mid-transaction aborts
    do_start(24'hC3_5A_99, 1'b0, 1);
    repeat (199) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t4_sclk_idle", 32'(scl), 32'd1);
    check("t4_sda_idle", 32'(sda), 32'd1);
    check("t4_busy", 32'(bus.busy), 32'd0);
    check("t4_done", 32'(bus.done), 32'd0);
    check("t4_ack_err", 32'(bus.ack_err), 32'd0);
    void'(exp_q.pop_back());
    rst = 1'b0;
    @(negedge clk);
    check("t4_no_done", 32'(bus.done), 32'd0);
    do_start(24'h3C_A5_0F, 1'b0, 1);
    wait_done("t4_new");

    // back-to-back: request in the first idle cycle after done
    do_start(24'h72_11_01, 1'b0, 1);
    wait_done("t6");

`ifdef SCCB_RETRY_EN
    // slave never ACKs: initial attempt plus MAX_RETRY retries
    nack_mask = 3'b111;
    do_start(24'h21_43_65, 1'b1, MAX_RETRY + 1);
    wait_done("t5");
    nack_mask = 3'b000;
`endif

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
